// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer: opcode encodings, flag layout and
// default sizes. Execute-stage opcodes are 6 bits wide; flags are {NG,ZR,CY,OV}.
package pc_sequencer_pkg;

  localparam int FlagWidth     = 4;
  localparam int RAS_DEPTH_DEF = 4;

  // Bit positions inside the {NG,ZR,CY,OV} flag word
  localparam int FLAG_NG = 3;
  localparam int FLAG_ZR = 2;
  localparam int FLAG_CY = 1;
  localparam int FLAG_OV = 0;

  // Control-flow opcodes resolved by the sequencer
  localparam logic [5:0] OP_NOP    = 6'h00;
  localparam logic [5:0] OP_B      = 6'h20;
  localparam logic [5:0] OP_BO     = 6'h21;
  localparam logic [5:0] OP_BNO    = 6'h22;
  localparam logic [5:0] OP_BLETU  = 6'h23;
  localparam logic [5:0] OP_BGTU   = 6'h24;
  localparam logic [5:0] OP_BLET   = 6'h25;
  localparam logic [5:0] OP_BGT    = 6'h26;
  localparam logic [5:0] OP_CALL   = 6'h27;
  localparam logic [5:0] OP_RET    = 6'h28;
  localparam logic [5:0] OP_RETI   = 6'h29;
  localparam logic [5:0] OP_SYSINT = 6'h2A;

endpackage

// File: rtl/pc_sequencer_branch_cond.sv
// Branch condition evaluator: opcode + effective flags -> taken.
// Latency: purely combinational.
// Backpressure: none; the caller gates with valid/stall.
module pc_sequencer_branch_cond
  import pc_sequencer_pkg::*;
(
  input  logic [5:0]           op_i,
  input  logic [FlagWidth-1:0] flags_i,
  output logic                 taken_o
);

  logic ng, zr, ov, unused_cy;
  assign ng        = flags_i[FLAG_NG];
  assign zr        = flags_i[FLAG_ZR];
  assign ov        = flags_i[FLAG_OV];
  assign unused_cy = flags_i[FLAG_CY];

  // Unconditional control flow always taken; conditional branches test the flags
  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      OP_B, OP_CALL, OP_SYSINT, OP_RET, OP_RETI: taken_o = 1'b1;
      OP_BO:    taken_o = zr;
      OP_BNO:   taken_o = !zr;
      OP_BLETU: taken_o = ng | zr;
      OP_BGTU:  taken_o = !(ng | zr);
      OP_BLET:  taken_o = (ng ^ ov) | zr;
      OP_BGT:   taken_o = !((ng ^ ov) | zr);
      default:  taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the fetch PC, drives the fetch handshake, resolves execute-stage redirects.
// Latency: redirect decided combinationally, flush and new fetch address one cycle later.
// Backpressure: stall holds PC/FSM/RAS; an issued fetch stays requested until acked.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                RAS_DEPTH = RAS_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(8)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 if_req,
  output logic [ADDR_W-1:0]    if_addr,
  input  logic                 if_ack,
  output logic                 id_valid,
  output logic [ADDR_W-1:0]    id_pc,
  input  logic                 ex_valid,
  input  logic [5:0]           ex_op,
  input  logic [ADDR_W-1:0]    ex_pc,
  input  logic [ADDR_W-1:0]    ex_target,
  input  logic                 flag_we,
  input  logic [FlagWidth-1:0] flag_in,
  input  logic                 stall,
  output logic                 flush,
  output logic [ADDR_W-1:0]    epc,
  output logic                 int_busy,
  output logic                 ras_err
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [1:0]           state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d, tgt_q, tgt_d, id_pc_q, id_pc_d;
  logic                 out_q, out_d, id_valid_q, id_valid_d;
  logic                 flush_q, busy_q, err_q;
  logic [ADDR_W-1:0]    epc_q;
  logic [FlagWidth-1:0] flag_q, flags_eff;
  logic [ADDR_W-1:0]    ras_q [RAS_DEPTH];
  logic [SP_W-1:0]      sp_q, sp_dec;
  logic [CNT_W-1:0]     cnt_q;
  logic                 cond_taken, taken, redir, ras_empty, ras_full;
  logic [ADDR_W-1:0]    target, ret_addr;

  // Same-cycle flag write bypasses the flag register for the condition
  assign flags_eff = flag_we ? flag_in : flag_q;

  pc_sequencer_branch_cond u_branch_cond (
    .op_i    (ex_op),
    .flags_i (flags_eff),
    .taken_o (cond_taken)
  );

  // A sysint arriving inside a handler is dropped; stall holds off every redirect
  assign taken     = ex_valid && cond_taken && !((ex_op == OP_SYSINT) && busy_q);
  assign redir     = taken && !stall && (state_q != ST_BOOT);
  assign sp_dec    = sp_q - SP_W'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ret_addr  = ex_pc + ADDR_W'(1);

  // Redirect target selection; an empty-stack return falls back to RESET_PC
  always_comb begin
    target = ex_target;
    case (ex_op)
      OP_RET:    target = ras_empty ? RESET_PC : ras_q[sp_dec];
      OP_RETI:   target = epc_q;
      OP_SYSINT: target = INT_VEC;
      default:   target = ex_target;
    endcase
  end

  // An issued-but-unacked fetch (out_q) keeps requesting even under stall
  assign if_req = (state_q == ST_DRAIN) || ((state_q == ST_RUN) && (!stall || out_q));

  // Fetch FSM: PC advance on ack, redirect, and draining a stale outstanding fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    out_d      = out_q;
    id_valid_d = 1'b0;
    id_pc_d    = id_pc_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        pc_d    = RESET_PC;
        out_d   = 1'b0;
      end
      ST_RUN: begin
        out_d = if_req && !if_ack;
        if (redir) begin
          if (!if_ack) begin
            state_d = ST_DRAIN;
            tgt_d   = target;
          end else begin
            pc_d = target;
          end
        end else if (if_req && if_ack && !stall) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        out_d = 1'b0;
        if (redir) tgt_d = target;
        if (if_ack) begin
          state_d = ST_RUN;
          pc_d    = redir ? target : tgt_q;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // Fetch-side state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      tgt_q      <= RESET_PC;
      out_q      <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      out_q      <= out_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Redirect side effects: flush pulse, flags, return stack, interrupt context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= 1'b0;
      flag_q  <= '0;
      epc_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      sp_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      flush_q <= redir;
      if (flag_we) flag_q <= flag_in;
      if (redir) begin
        case (ex_op)
          OP_CALL: begin
            // Full stack: the write slot holds the oldest entry, so it is overwritten
            ras_q[sp_q] <= ret_addr;
            sp_q        <= sp_q + SP_W'(1);
            if (ras_full) err_q <= 1'b1;
            else          cnt_q <= cnt_q + CNT_W'(1);
          end
          OP_RET: begin
            if (ras_empty) begin
              err_q <= 1'b1;
            end else begin
              sp_q  <= sp_dec;
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          OP_SYSINT: begin
            epc_q  <= ret_addr;
            busy_q <= 1'b1;
          end
          OP_RETI: busy_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign if_addr  = pc_q;
  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign flush    = flush_q;
  assign epc      = epc_q;
  assign int_busy = busy_q;
  assign ras_err  = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a transaction-level reference model.
// Inputs change just after the rising edge; outputs are compared on the falling edge.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk, rst_n;
  logic        if_req, if_ack, id_valid, ex_valid, flag_we, stall, flush, int_busy, ras_err;
  logic [15:0] if_addr, id_pc, ex_pc, ex_target, epc;
  logic [5:0]  ex_op;
  logic [3:0]  flag_in;

  int n_chk  = 0;
  int n_fail = 0;

  pc_sequencer #(
    .ADDR_W(16), .RAS_DEPTH(4), .RESET_PC(16'h0000), .INT_VEC(16'h0008)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .id_valid(id_valid), .id_pc(id_pc),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_pc(ex_pc), .ex_target(ex_target),
    .flag_we(flag_we), .flag_in(flag_in), .stall(stall),
    .flush(flush), .epc(epc), .int_busy(int_busy), .ras_err(ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase;   // 0 boot, 1 running, 2 waiting out a stale fetch
  logic [15:0] m_addr, m_pend, m_idpc, m_epc;
  logic        m_out, m_idv, m_flush, m_busy, m_err;
  logic [3:0]  m_flags;
  logic [15:0] m_ras[$];

  function automatic logic cond(input logic [5:0] op, input logic [3:0] f);
    logic ng, zr, ov;
    ng = f[3]; zr = f[2]; ov = f[0];
    case (op)
      OP_B, OP_CALL, OP_SYSINT, OP_RET, OP_RETI: return 1'b1;
      OP_BO:    return zr;
      OP_BNO:   return !zr;
      OP_BLETU: return ng || zr;
      OP_BGTU:  return !(ng || zr);
      OP_BLET:  return (ng != ov) || zr;
      OP_BGT:   return !((ng != ov) || zr);
      default:  return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin : model
    logic [3:0]  f;
    logic [15:0] tgt;
    logic        e_req, go, nidv;
    if (!rst_n) begin
      chk1("rst if_req", if_req, 1'b0);
      chk16("rst if_addr", if_addr, 16'h0000);
      chk1("rst id_valid", id_valid, 1'b0);
      chk16("rst id_pc", id_pc, 16'h0000);
      chk1("rst flush", flush, 1'b0);
      chk16("rst epc", epc, 16'h0000);
      chk1("rst int_busy", int_busy, 1'b0);
      chk1("rst ras_err", ras_err, 1'b0);
      m_phase = 0; m_addr = 16'h0000; m_pend = 16'h0000; m_idpc = 16'h0000;
      m_epc = 16'h0000; m_out = 1'b0; m_idv = 1'b0; m_flush = 1'b0;
      m_busy = 1'b0; m_err = 1'b0; m_flags = 4'h0; m_ras.delete();
    end else begin
      e_req = (m_phase == 2) || (m_phase == 1 && (!stall || m_out));
      chk1("model if_req", if_req, e_req);
      chk16("model if_addr", if_addr, m_addr);
      chk1("model id_valid", id_valid, m_idv);
      if (m_idv) chk16("model id_pc", id_pc, m_idpc);
      chk1("model flush", flush, m_flush);
      chk16("model epc", epc, m_epc);
      chk1("model int_busy", int_busy, m_busy);
      chk1("model ras_err", ras_err, m_err);

      f   = flag_we ? flag_in : m_flags;
      go  = ex_valid && cond(ex_op, f) && !(ex_op == OP_SYSINT && m_busy)
            && !stall && (m_phase != 0);
      tgt = ex_target;
      if (go) begin
        case (ex_op)
          OP_CALL: begin
            m_ras.push_back(ex_pc + 16'd1);
            if (m_ras.size() > 4) begin
              void'(m_ras.pop_front());
              m_err = 1'b1;
            end
          end
          OP_RET: begin
            if (m_ras.size() > 0) tgt = m_ras.pop_back();
            else begin tgt = 16'h0000; m_err = 1'b1; end
          end
          OP_RETI:   begin tgt = m_epc; m_busy = 1'b0; end
          OP_SYSINT: begin tgt = 16'h0008; m_epc = ex_pc + 16'd1; m_busy = 1'b1; end
          default: ;
        endcase
      end

      nidv = 1'b0;
      if (m_phase == 0) begin
        m_phase = 1; m_addr = 16'h0000; m_out = 1'b0;
      end else if (m_phase == 1) begin
        if (go) begin
          if (!if_ack) begin m_phase = 2; m_pend = tgt; end
          else m_addr = tgt;
          m_out = 1'b0;
        end else begin
          if (e_req && if_ack && !stall) begin
            nidv = 1'b1; m_idpc = m_addr; m_addr = m_addr + 16'd1;
          end
          m_out = e_req && !if_ack;
        end
      end else begin
        if (go) m_pend = tgt;
        if (if_ack) begin m_phase = 1; m_addr = m_pend; end
        m_out = 1'b0;
      end
      m_idv   = nidv;
      m_flush = go;
      if (flag_we) m_flags = flag_in;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic issue(input logic [5:0] op, input logic [15:0] pc, input logic [15:0] tgt);
    ex_valid = 1'b1; ex_op = op; ex_pc = pc; ex_target = tgt;
    cyc();
    ex_valid = 1'b0; ex_op = OP_NOP;
  endtask

  logic [5:0] sweep_ops [7] = '{OP_BLETU, OP_BGTU, OP_BLET, OP_BGT, OP_BO, OP_BNO, OP_NOP};
  logic [3:0] sweep_fl  [5] = '{4'h0, 4'h4, 4'h8, 4'h9, 4'h1};

  initial begin
    rst_n = 1'b0; if_ack = 1'b1; ex_valid = 1'b0; ex_op = OP_NOP; ex_pc = 16'h0;
    ex_target = 16'h0; flag_we = 1'b0; flag_in = 4'h0; stall = 1'b0;
    repeat (3) cyc();
    look();
    chk1("reset if_req", if_req, 1'b0);
    chk16("reset if_addr", if_addr, 16'h0000);

    // Boot and streaming fetch with if_ack tied high
    cyc(); rst_n = 1'b1; look();
    chk1("boot if_req", if_req, 1'b0);
    cyc(); look();
    chk1("c1 if_req", if_req, 1'b1);
    chk16("c1 if_addr", if_addr, 16'h0000);
    cyc(); look();
    chk16("c2 if_addr", if_addr, 16'h0001);
    chk1("c2 id_valid", id_valid, 1'b1);
    chk16("c2 id_pc", id_pc, 16'h0000);
    cyc(); look();
    chk16("c3 if_addr", if_addr, 16'h0002);
    chk1("c3 flush", flush, 1'b0);

    // bo taken on ZR, then bno not taken
    flag_we = 1'b1; flag_in = 4'b0100;
    cyc(); flag_we = 1'b0;
    issue(OP_BO, 16'h0030, 16'h0040); look();
    chk1("bo flush", flush, 1'b1);
    chk16("bo if_addr", if_addr, 16'h0040);
    chk1("bo squash", id_valid, 1'b0);
    issue(OP_BNO, 16'h0031, 16'h0080); look();
    chk1("bno flush", flush, 1'b0);
    chk16("bno if_addr", if_addr, 16'h0041);
    chk16("bno id_pc", id_pc, 16'h0040);

    // call / ret pair
    issue(OP_CALL, 16'h0010, 16'h0100); look();
    chk16("call if_addr", if_addr, 16'h0100);
    repeat (2) cyc();
    issue(OP_RET, 16'h0102, 16'h0000); look();
    chk16("ret if_addr", if_addr, 16'h0011);
    chk1("ret flush", flush, 1'b1);

    // overflow then underflow of the return stack
    for (int i = 0; i < 4; i++) issue(OP_CALL, 16'h0200 + 16'(i), 16'h0400 + 16'(i));
    look();
    chk1("4 calls ras_err", ras_err, 1'b0);
    issue(OP_CALL, 16'h0204, 16'h0404); look();
    chk1("5 calls ras_err", ras_err, 1'b1);
    chk16("5th call if_addr", if_addr, 16'h0404);
    for (int i = 0; i < 4; i++) begin
      issue(OP_RET, 16'h0500, 16'h0000); look();
      chk16("ret pop if_addr", if_addr, 16'h0205 - 16'(i));
    end
    issue(OP_RET, 16'h0500, 16'h0000); look();
    chk16("empty ret if_addr", if_addr, 16'h0000);

    // sysint, ignored nested sysint, reti
    issue(OP_SYSINT, 16'h0020, 16'h0999); look();
    chk16("sysint if_addr", if_addr, 16'h0008);
    chk16("sysint epc", epc, 16'h0021);
    chk1("sysint busy", int_busy, 1'b1);
    issue(OP_SYSINT, 16'h0030, 16'h0999); look();
    chk1("nested sysint flush", flush, 1'b0);
    chk16("nested sysint epc", epc, 16'h0021);
    chk16("nested sysint if_addr", if_addr, 16'h0009);
    issue(OP_RETI, 16'h0009, 16'h0000); look();
    chk16("reti if_addr", if_addr, 16'h0021);
    chk1("reti busy", int_busy, 1'b0);

    // redirect with fetch outstanding, second redirect while draining
    if_ack = 1'b0;
    issue(OP_B, 16'h0040, 16'h0300); look();
    chk1("drain flush", flush, 1'b1);
    chk16("drain hold addr", if_addr, 16'h0021);
    chk1("drain if_req", if_req, 1'b1);
    issue(OP_B, 16'h0041, 16'h0310); look();
    chk16("drain hold addr2", if_addr, 16'h0021);
    cyc(); if_ack = 1'b1;
    cyc(); look();
    chk16("drain target addr", if_addr, 16'h0310);
    chk1("drain stale id_valid", id_valid, 1'b0);
    cyc(); look();
    chk1("after drain id_valid", id_valid, 1'b1);
    chk16("after drain id_pc", id_pc, 16'h0310);

    // stall with and without an outstanding fetch
    cyc(); stall = 1'b1; look();
    chk1("stall if_req", if_req, 1'b0);
    cyc(); stall = 1'b0; if_ack = 1'b0; look();
    chk16("stall frozen addr", if_addr, 16'h0312);
    cyc(); stall = 1'b1; look();
    chk1("stall outstanding req", if_req, 1'b1);
    cyc(); if_ack = 1'b1;
    cyc(); stall = 1'b0; look();
    chk1("stalled ack dropped", id_valid, 1'b0);
    chk16("refetch addr", if_addr, 16'h0312);
    cyc(); look();
    chk16("refetch id_pc", id_pc, 16'h0312);

    // flag bypass
    flag_we = 1'b1; flag_in = 4'h0;
    cyc(); flag_in = 4'b1000;
    issue(OP_BLET, 16'h0050, 16'h0500); look();
    chk16("blet bypass if_addr", if_addr, 16'h0500);
    flag_in = 4'b1001;
    issue(OP_BGT, 16'h0051, 16'h0520); look();
    chk16("bgt bypass if_addr", if_addr, 16'h0520);
    flag_we = 1'b0;
    issue(OP_BLET, 16'h0052, 16'h0540); look();
    chk1("blet not taken flush", flush, 1'b0);
    chk16("blet not taken addr", if_addr, 16'h0521);

    // condition sweep checked by the model
    flag_we = 1'b1;
    for (int o = 0; o < 7; o++)
      for (int k = 0; k < 5; k++) begin
        flag_in = sweep_fl[k];
        issue(sweep_ops[o], 16'h0060, 16'h0600 + 16'(o * 5 + k));
      end
    flag_we = 1'b0;

    // reset pulse while draining
    if_ack = 1'b0;
    issue(OP_B, 16'h0070, 16'h0700);
    cyc(); rst_n = 1'b0; look();
    chk1("mid-drain rst if_req", if_req, 1'b0);
    chk16("mid-drain rst epc", epc, 16'h0000);
    chk1("mid-drain rst ras_err", ras_err, 1'b0);
    cyc(); rst_n = 1'b1; if_ack = 1'b1;
    cyc(); look();
    chk16("post-reset if_addr", if_addr, 16'h0000);
    chk1("post-reset if_req", if_req, 1'b1);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
